// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: menu-driven fan levels, timed turbo,
// delayed exit, self-clean cycle and post-stop menu lockout.
module hood_mode_ctrl #(
    parameter int NUM_SPEEDS  = 3,
    parameter int TICK_CYCLES = 100_000_000,
    parameter int TURBO_SEC   = 60,
    parameter int EXIT_SEC    = 60,
    parameter int CLEAN_SEC   = 180,
    parameter int LOCK_SEC    = 5,
    parameter int TURBO_LIMIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  power_on,
    input  logic                  menu,
    input  logic [NUM_SPEEDS-1:0] speed_req,
    input  logic                  clean,
    output logic [2:0]            state,
    output logic [2:0]            fan_level,
    output logic [15:0]           remain_sec,
    output logic                  clean_done,
    output logic                  locked,
    output logic [3:0]            turbo_left
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TICK_CYCLES - 1);
    localparam logic [2:0] TOP = 3'(NUM_SPEEDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MENU  = 3'd1,
        RUN   = 3'd2,
        TURBO = 3'd3,
        EXIT  = 3'd4,
        CLEAN = 3'd5
    } state_t;

    state_t        st_q, st_n;
    logic [2:0]    fan_q, fan_n;
    logic [15:0]   rem_q, rem_n;
    logic [3:0]    tl_q, tl_n;
    logic          lock_q, lock_n;
    logic [15:0]   lcnt_q, lcnt_n;
    logic          cd_q, cd_n;
    logic [TW-1:0] ccnt_q, ccnt_n;
    logic [TW-1:0] tick_q, tick_n;

    logic          tick;
    logic          found;
    logic [2:0]    idx;

    assign tick = (tick_q == TMAX);

    // Lowest requested speed bit wins
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int k = NUM_SPEEDS - 1; k >= 0; k--) begin
            if (speed_req[k]) begin
                found = 1'b1;
                idx   = 3'(k);
            end
        end
    end

    // Next-state, timers and output values
    always_comb begin
        st_n   = st_q;
        fan_n  = fan_q;
        rem_n  = rem_q;
        tl_n   = tl_q;
        lock_n = lock_q;
        lcnt_n = lcnt_q;
        cd_n   = cd_q;
        ccnt_n = ccnt_q;
        tick_n = tick ? '0 : tick_q + 1'b1;

        if (lock_q && tick) begin
            if (lcnt_q <= 16'd1) begin
                lock_n = 1'b0;
                lcnt_n = '0;
            end else begin
                lcnt_n = lcnt_q - 16'd1;
            end
        end

        if (cd_q) begin
            if (ccnt_q == '0) cd_n = 1'b0;
            else ccnt_n = ccnt_q - 1'b1;
        end

        case (st_q)
            IDLE: begin
                fan_n = '0;
                if (menu && !lock_q) st_n = MENU;
            end
            MENU: begin
                if (found) begin
                    if (idx < TOP) begin
                        st_n  = RUN;
                        fan_n = idx + 3'd1;
                    end else if (tl_q != '0) begin
                        st_n  = TURBO;
                        fan_n = 3'(NUM_SPEEDS);
                        rem_n = 16'(TURBO_SEC);
                        tl_n  = tl_q - 4'd1;
                    end
                end else if (clean) begin
                    st_n  = CLEAN;
                    fan_n = '0;
                    rem_n = 16'(CLEAN_SEC);
                end
            end
            RUN: begin
                if (menu) begin
                    st_n   = IDLE;
                    fan_n  = '0;
                    lock_n = 1'b1;
                    lcnt_n = 16'(LOCK_SEC);
                end else if (found && idx < TOP) begin
                    fan_n = idx + 3'd1;
                end
            end
            TURBO: begin
                if (menu) begin
                    st_n  = EXIT;
                    rem_n = 16'(EXIT_SEC);
                end else if (tick) begin
                    if (rem_q <= 16'd1) begin
                        st_n  = RUN;
                        fan_n = TOP;
                        rem_n = '0;
                    end else begin
                        rem_n = rem_q - 16'd1;
                    end
                end
            end
            EXIT: begin
                if (tick) begin
                    if (rem_q <= 16'd1) begin
                        st_n  = IDLE;
                        fan_n = '0;
                        rem_n = '0;
                    end else begin
                        rem_n = rem_q - 16'd1;
                    end
                end
            end
            CLEAN: begin
                if (tick) begin
                    if (rem_q <= 16'd1) begin
                        st_n   = IDLE;
                        rem_n  = '0;
                        cd_n   = 1'b1;
                        ccnt_n = TMAX;
                    end else begin
                        rem_n = rem_q - 16'd1;
                    end
                end
            end
            default: begin
                st_n  = IDLE;
                fan_n = '0;
                rem_n = '0;
            end
        endcase

        if (st_n != st_q) tick_n = '0;
    end

    // State and timer registers; power loss behaves like reset
    always_ff @(posedge clk) begin
        if (rst || !power_on) begin
            st_q   <= IDLE;
            fan_q  <= '0;
            rem_q  <= '0;
            tl_q   <= 4'(TURBO_LIMIT);
            lock_q <= 1'b0;
            lcnt_q <= '0;
            cd_q   <= 1'b0;
            ccnt_q <= '0;
            tick_q <= '0;
        end else begin
            st_q   <= st_n;
            fan_q  <= fan_n;
            rem_q  <= rem_n;
            tl_q   <= tl_n;
            lock_q <= lock_n;
            lcnt_q <= lcnt_n;
            cd_q   <= cd_n;
            ccnt_q <= ccnt_n;
            tick_q <= tick_n;
        end
    end

    assign state      = st_q;
    assign fan_level  = fan_q;
    assign remain_sec = rem_q;
    assign clean_done = cd_q;
    assign locked     = lock_q;
    assign turbo_left = tl_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl with short tick and timer settings.
module tb_hood_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        power_on = 1'b1;
    logic        menu = 1'b0;
    logic [2:0]  speed_req = '0;
    logic        clean = 1'b0;
    logic [2:0]  state;
    logic [2:0]  fan_level;
    logic [15:0] remain_sec;
    logic        clean_done;
    logic        locked;
    logic [3:0]  turbo_left;

    int tests = 0;
    int fails = 0;

    hood_mode_ctrl #(
        .NUM_SPEEDS(3), .TICK_CYCLES(4), .TURBO_SEC(3), .EXIT_SEC(2),
        .CLEAN_SEC(3), .LOCK_SEC(2), .TURBO_LIMIT(1)
    ) dut (
        .clk(clk), .rst(rst), .power_on(power_on), .menu(menu),
        .speed_req(speed_req), .clean(clean), .state(state),
        .fan_level(fan_level), .remain_sec(remain_sec),
        .clean_done(clean_done), .locked(locked), .turbo_left(turbo_left)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pmenu();
        menu = 1'b1;
        cyc(1);
        menu = 1'b0;
    endtask

    task automatic pspeed(input logic [2:0] v, input logic c);
        speed_req = v;
        clean = c;
        cyc(1);
        speed_req = '0;
        clean = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        chk("rst_state", 32'(state), 0);
        chk("rst_fan", 32'(fan_level), 0);
        chk("rst_rem", 32'(remain_sec), 0);
        chk("rst_cd", 32'(clean_done), 0);
        chk("rst_lock", 32'(locked), 0);
        chk("rst_tl", 32'(turbo_left), 1);

        // menu -> run at level 2 -> stop with lockout
        pmenu();
        chk("menu_state", 32'(state), 1);
        pspeed(3'b010, 1'b0);
        chk("run_state", 32'(state), 2);
        chk("run_fan", 32'(fan_level), 2);
        pmenu();
        chk("stop_state", 32'(state), 0);
        chk("stop_lock", 32'(locked), 1);
        pmenu();
        chk("lock_ign_state", 32'(state), 0);
        cyc(6);
        chk("lock_hold", 32'(locked), 1);
        cyc(1);
        chk("lock_drop", 32'(locked), 0);

        // turbo with auto step-down
        pmenu();
        pspeed(3'b100, 1'b0);
        chk("turbo_state", 32'(state), 3);
        chk("turbo_fan", 32'(fan_level), 3);
        chk("turbo_rem", 32'(remain_sec), 3);
        chk("turbo_tl", 32'(turbo_left), 0);
        cyc(4);
        chk("turbo_rem2", 32'(remain_sec), 2);
        cyc(7);
        chk("turbo_last_state", 32'(state), 3);
        chk("turbo_last_rem", 32'(remain_sec), 1);
        cyc(1);
        chk("stepdown_state", 32'(state), 2);
        chk("stepdown_fan", 32'(fan_level), 2);
        chk("stepdown_rem", 32'(remain_sec), 0);

        // turbo limit exhausted, restored by power cycle
        pmenu();
        cyc(8);
        chk("lock2_drop", 32'(locked), 0);
        pmenu();
        pspeed(3'b100, 1'b0);
        chk("turbo_denied", 32'(state), 1);
        power_on = 1'b0;
        cyc(1);
        power_on = 1'b1;
        chk("pwr_state", 32'(state), 0);
        chk("pwr_tl", 32'(turbo_left), 1);

        // turbo exit via delayed off
        pmenu();
        pspeed(3'b100, 1'b0);
        cyc(4);
        chk("t2_rem", 32'(remain_sec), 2);
        pmenu();
        chk("exit_state", 32'(state), 4);
        chk("exit_rem", 32'(remain_sec), 2);
        chk("exit_fan", 32'(fan_level), 3);
        cyc(7);
        chk("exit_last", 32'(state), 4);
        cyc(1);
        chk("exit_idle", 32'(state), 0);
        chk("exit_fan0", 32'(fan_level), 0);
        chk("exit_nolock", 32'(locked), 0);

        // self-clean and completion pulse
        pmenu();
        pspeed(3'b000, 1'b1);
        chk("clean_state", 32'(state), 5);
        chk("clean_rem", 32'(remain_sec), 3);
        chk("clean_fan", 32'(fan_level), 0);
        cyc(11);
        chk("clean_last", 32'(state), 5);
        cyc(1);
        chk("clean_idle", 32'(state), 0);
        chk("cd_first", 32'(clean_done), 1);
        cyc(3);
        chk("cd_last", 32'(clean_done), 1);
        cyc(1);
        chk("cd_off", 32'(clean_done), 0);

        // speed wins over clean
        pmenu();
        pspeed(3'b001, 1'b1);
        chk("prio_state", 32'(state), 2);
        chk("prio_fan", 32'(fan_level), 1);

        // reset mid-clean with simultaneous menu
        pmenu();
        cyc(8);
        pmenu();
        pspeed(3'b000, 1'b1);
        cyc(4);
        chk("c2_rem", 32'(remain_sec), 2);
        rst = 1'b1;
        menu = 1'b1;
        cyc(1);
        rst = 1'b0;
        menu = 1'b0;
        chk("mrst_state", 32'(state), 0);
        chk("mrst_rem", 32'(remain_sec), 0);
        chk("mrst_fan", 32'(fan_level), 0);
        chk("mrst_tl", 32'(turbo_left), 1);
        chk("mrst_cd", 32'(clean_done), 0);
        cyc(1);
        chk("mrst_after", 32'(state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_SPEEDS, default 3, number of fan levels; the top level is turbo; legal range 2..7.
REQ-002 SHALL have parameter TICK_CYCLES, default 100_000_000, clk cycles per one-second tick.
REQ-003 SHALL have parameter TURBO_SEC, default 60, turbo run time before auto step-down.
REQ-004 SHALL have parameter EXIT_SEC, default 60, delayed-off time when menu is pressed in turbo.
REQ-005 SHALL have parameter CLEAN_SEC, default 180, self-clean duration.
REQ-006 SHALL have parameter LOCK_SEC, default 5, menu lockout after a normal stop.
REQ-007 SHALL have parameter TURBO_LIMIT, default 1, turbo entries allowed per power-on; legal range 1..15.
REQ-008 SHALL have port clk, input, 1, sole clock.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port power_on, input, 1, level; low acts as synchronous reset.
REQ-011 SHALL have port menu, input, 1, single-cycle debounced pulse.
REQ-012 SHALL have port speed_req, input, NUM_SPEEDS, pulses; bit k requests level k+1.
REQ-013 SHALL have port clean, input, 1, single-cycle pulse.
REQ-014 SHALL have port state, output, 3: IDLE=0, MENU=1, RUN=2, TURBO=3, EXIT=4, CLEAN=5.
REQ-015 SHALL have port fan_level, output, 3, 0 = off.
REQ-016 SHALL have port remain_sec, output, 16, seconds left in TURBO/EXIT/CLEAN, else 0.
REQ-017 SHALL have port clean_done, output, 1, held high for one tick after clean completes.
REQ-018 SHALL have port locked, output, 1, high during menu lockout.
REQ-019 SHALL have port turbo_left, output, 4, remaining turbo entries.

Function
REQ-020 All outputs SHALL be registered; a state change SHALL be visible one cycle after the qualifying input cycle.
REQ-021 The tick counter SHALL count 0..TICK_CYCLES-1 and wrap; each wrap SHALL be one tick; the counter SHALL restart at 0 on every state entry.
REQ-022 IDLE: menu with locked=0 SHALL go to MENU; menu with locked=1 SHALL be ignored; fan_level=0.
REQ-023 MENU: the lowest set bit of speed_req SHALL win; bit k<NUM_SPEEDS-1 SHALL go to RUN with fan_level=k+1.
REQ-024 MENU: the top bit with turbo_left>0 SHALL go to TURBO, load remain_sec=TURBO_SEC, and decrement turbo_left; with turbo_left=0 it SHALL be ignored.
REQ-025 MENU: clean with no speed bit set SHALL go to CLEAN with remain_sec=CLEAN_SEC and fan_level=0; speed_req SHALL take priority over clean; menu SHALL stay in MENU.
REQ-026 RUN: a non-top speed_req bit SHALL change fan_level in place; the top bit SHALL be ignored; menu SHALL go to IDLE, set locked, and load the lockout count LOCK_SEC; menu SHALL take priority over speed_req.
REQ-027 TURBO: fan_level=NUM_SPEEDS; remain_sec SHALL decrement per tick; on reaching 0 it SHALL go to RUN at NUM_SPEEDS-1.
REQ-028 TURBO: menu SHALL go to EXIT with remain_sec=EXIT_SEC and fan_level unchanged; speed_req and clean SHALL be ignored.
REQ-029 EXIT: remain_sec SHALL decrement per tick; at 0 it SHALL go to IDLE with fan_level=0 and no lockout; all inputs SHALL be ignored.
REQ-030 CLEAN: remain_sec SHALL decrement per tick; at 0 it SHALL go to IDLE and pulse clean_done for TICK_CYCLES cycles; all inputs SHALL be ignored.
REQ-031 The lockout count SHALL decrement per tick, independent of state; at 0, locked SHALL drop.
REQ-032 The clean_done window and the lockout SHALL count concurrently without interfering.
REQ-033 remain_sec SHALL saturate at 0 and never wrap.

Reset
REQ-034 On rst=1 or power_on=0 at a clk edge, all outputs SHALL clear to 0 (state=IDLE) and turbo_left SHALL load TURBO_LIMIT; this SHALL hold mid-operation in any state.
REQ-035 When rst and power_on are both asserted, the reset SHALL take precedence over every input in the same cycle.

Verification (TICK_CYCLES=4, TURBO_SEC=3, EXIT_SEC=2, CLEAN_SEC=3, LOCK_SEC=2, NUM_SPEEDS=3, TURBO_LIMIT=1)
REQ-036 menu, then speed_req=3'b010 -> state=2 and fan_level=2 on the cycle after each input; menu -> state=0 and locked=1 for 8 cycles; menu during the lock -> ignored.
REQ-037 menu, then speed_req=3'b100 -> state=3, fan_level=3, remain_sec=3, turbo_left=0; after 12 cycles -> state=2, fan_level=2.
REQ-038 A second turbo request after REQ-037 (menu, menu-from-RUN after the lock, speed_req=3'b100) -> stays in MENU; after power_on toggled low then high -> turbo_left=1.
REQ-039 In TURBO with remain_sec=2, pulse menu -> state=4, remain_sec=2; after 8 cycles -> state=0, fan_level=0, locked=0.
REQ-040 menu, then clean -> state=5, remain_sec=3; after 12 cycles -> state=0 and clean_done=1 for 4 cycles; speed_req=3'b001 sent together with clean from MENU -> RUN instead of CLEAN.
REQ-041 Assert rst mid-CLEAN with remain_sec=2 -> next cycle all outputs=0, turbo_left=1; a menu pulse in the same cycle as rst has no effect.
